clock_time_counter: RTL and testbench
=====================================

Name: clock_time_counter

Overview:
- Time-keeping core of the digital clock. Counts seconds, minutes and hours in 24-hour binary format from a periodic tick enable.
- The 5-bit hour output feeds the downstream 24h-to-12h converter directly. Minute and second outputs feed the display path.
- Supports synchronous time loading through a valid/ready handshake, manual minute/hour increment, and pause.

Parameters:
- PRESCALE, 1, number of tick_in pulses per second (1 = tick_in is already 1 Hz). Legal range 1..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick_in  in  1  one-cycle enable pulse; PRESCALE pulses advance time by 1 s
- pause  in  1  level; high freezes counting (tick_in ignored)
- set_valid  in  1  load request
- set_ready  out  1  block can accept a load this cycle
- set_hour  in  5  load value, 0..23
- set_min  in  6  load value, 0..59
- set_sec  in  6  load value, 0..59
- set_err  out  1  one-cycle pulse: load rejected, value out of range
- inc_min  in  1  one-cycle pulse: minute +1
- inc_hour  in  1  one-cycle pulse: hour +1
- hour24  out  5  current hour, 0..23
- minute  out  6  current minute, 0..59
- second  out  6  current second, 0..59
- min_tick  out  1  one-cycle pulse on second 59->0 rollover
- day_tick  out  1  one-cycle pulse on 23:59:59->00:00:00

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - hour24/minute/second = 0 and prescaler = 0.
  - set_ready = 1; set_err, min_tick, day_tick = 0.
  - State = RUN.
- FSM states:
  - RUN: counting enabled.
  - PAUSE: counting disabled.
  - LOAD: one-cycle load commit.
  - RUN<->PAUSE follows the pause input on the next edge.
  - Handshake fire (set_valid & set_ready) with in-range values -> LOAD. LOAD always exits after 1 cycle to RUN or PAUSE, chosen by pause.
- Handshake:
  - set_ready = 1 in RUN/PAUSE and 0 in LOAD.
  - Load values are captured on the fire edge. Outputs show the new time in the cycle after fire.
  - LOAD clears the prescaler to 0.
- Range check: set_hour>23, set_min>59 or set_sec>59 -> no state change, no LOAD, set_err=1 for exactly the next cycle. set_ready stays 1.
- Counting (RUN only):
  - Each tick_in increments the prescaler. At PRESCALE-1 it wraps to 0 and second increments.
  - Carry chain: sec 59->0 carries to minute (min_tick=1); minute 59->0 carries to hour; hour 23->0 with min 59 and sec 59 -> day_tick=1.
  - All three fields update on the same edge. Pulse outputs are registered and align with the edge at which the new time appears.
- Manual increment:
  - inc_min: minute +1, wraps 59->0 with no carry. Seconds and prescaler unchanged.
  - inc_hour: hour +1, wraps 23->0, no day_tick.
  - Both are honoured in RUN and PAUSE and ignored in LOAD.
  - inc_min and inc_hour in the same cycle: both apply.
- Priority per cycle: rst > load fire > inc_min/inc_hour > tick carry.
  - Inc and tick in the same cycle: the inc is applied and the tick is still counted into the prescaler. If that tick would advance the seconds, only the second field advances; the inc'd field wins and carries into it are dropped.
- Reset mid-load: LOAD is aborted and the reset values apply.
- Latency: tick_in to second update = 1 clk. Load fire to outputs = 1 clk.

Optional Feature:
- CLOCK_ALARM_EN defined:
  - Adds inputs alarm_en(1), alarm_hour(5), alarm_min(6) and output alarm(1).
  - alarm pulses one cycle when a tick-driven update produces hour24==alarm_hour, minute==alarm_min and second==0, with alarm_en=1.
  - Loads and manual increments never fire alarm.
  - Reset value of alarm is 0.
- Undefined: these ports and the logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package clock_pkg holds:
  - HOUR_W=5, MIN_W=6, SEC_W=6
  - MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59
  - FSM state enum {RUN, PAUSE, LOAD}
- Sub-module mod_counter: parameterised width/modulus counter with enable, load, inc and carry-out. Instantiated three times for sec, min and hour.
- The prescaler stays inline.

Test Plan:
- rst; PRESCALE=1; 60 tick_in pulses -> second 59 then 0, minute=1, min_tick high exactly one cycle.
- Load 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00 with day_tick=1 and min_tick=1 on the same cycle.
- set_valid with set_hour=24 -> time unchanged, set_err=1 for one cycle, set_ready stays 1. Then a valid load of 12:30:00 -> set_ready=0 for one cycle, outputs 12:30:00 on the next cycle.
- pause=1, 10 ticks -> time frozen. inc_hour at hour 23 -> 0 with no day_tick. inc_min at 59 -> 0 with hour unchanged.
- PRESCALE=4: 3 ticks -> second unchanged; 4th tick -> second+1. Load mid-prescale, then 3 ticks -> no advance (prescaler cleared).
- CLOCK_ALARM_EN: alarm 07:00, load 06:59:59, 1 tick -> alarm pulse. Load 07:00:00 directly -> no alarm.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared widths, limits and FSM encoding for the clock time-keeping core.
package clock_pkg;

  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned SEC_W    = 6;
  localparam int unsigned PRE_W    = 16;

  localparam int unsigned MAX_HOUR = 23;
  localparam int unsigned MAX_MIN  = 59;
  localparam int unsigned MAX_SEC  = 59;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    LOAD  = 2'd2
  } state_e;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with load, manual increment and tick-driven carry-out.
// Priority inside the counter: load > inc > en. A manual increment wraps
// silently; only an enable-driven wrap raises o_carry_c.
module mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned WIDTH   = SEC_W,
  parameter int unsigned MODULUS = MAX_SEC + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_inc,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_value,
  output logic             o_carry_c
);

  logic [WIDTH-1:0] r_value;
  logic             w_at_max;
  logic             w_step;

  assign w_at_max  = (r_value == WIDTH'(MODULUS - 1));
  assign w_step    = ~i_load & (i_inc | i_en);
  assign o_carry_c = ~i_load & ~i_inc & i_en & w_at_max;
  assign o_value   = r_value;

  // Count register: load, or step with wrap at MODULUS-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (w_step) begin
      r_value <= w_at_max ? '0 : r_value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// 24-hour hh:mm:ss time-keeping core driven by a prescaled tick enable.
// Optional alarm comparator is built when CLOCK_ALARM_EN is defined.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_in,
  input  logic              pause,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [SEC_W-1:0]  set_sec,
  output logic              set_err,
  input  logic              inc_min,
  input  logic              inc_hour,
  output logic [HOUR_W-1:0] hour24,
  output logic [MIN_W-1:0]  minute,
  output logic [SEC_W-1:0]  second,
  output logic              min_tick,
  output logic              day_tick
`ifdef CLOCK_ALARM_EN
  ,
  input  logic              alarm_en,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  output logic              alarm
`endif
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_set_ready;
  logic             w_ready_nxt;
  logic             r_set_err;
  logic             r_min_tick;
  logic             r_day_tick;
  logic [PRE_W-1:0] r_pre;

  logic w_fire;
  logic w_in_range;
  logic w_load;
  logic w_inc_ok;
  logic w_inc_min;
  logic w_inc_hour;
  logic w_any_inc;
  logic w_tick;
  logic w_sec_adv;
  logic w_sec_carry;
  logic w_min_carry;
  logic w_hour_carry;

  // Handshake decode and qualified control strobes.
  assign w_fire     = set_valid & r_set_ready;
  assign w_in_range = (set_hour <= HOUR_W'(MAX_HOUR)) &
                      (set_min  <= MIN_W'(MAX_MIN))   &
                      (set_sec  <= SEC_W'(MAX_SEC));
  assign w_load     = w_fire & w_in_range;
  assign w_inc_ok   = (r_state != LOAD) & ~w_load;
  assign w_inc_min  = inc_min  & w_inc_ok;
  assign w_inc_hour = inc_hour & w_inc_ok;
  assign w_any_inc  = w_inc_min | w_inc_hour;
  assign w_tick     = (r_state == RUN) & tick_in & ~w_load;
  assign w_sec_adv  = w_tick & (r_pre == PRE_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_set_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_set_ready <= w_ready_nxt;
    end
  end

  // Next state: a good load wins, otherwise follow the pause level.
  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = 1'b1;
    if (w_load) begin
      w_state_nxt = LOAD;
    end else if (pause) begin
      w_state_nxt = PAUSE;
    end else begin
      w_state_nxt = RUN;
    end
    w_ready_nxt = (w_state_nxt != LOAD);
  end

  // Tick prescaler; cleared by reset and by a load.
  always_ff @(posedge clk) begin
    if (rst || w_load) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + PRE_W'(1);
    end
  end

  mod_counter #(
    .WIDTH   (SEC_W),
    .MODULUS (MAX_SEC + 1)
  ) u_sec (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_sec_adv),
    .i_inc      (1'b0),
    .i_load     (w_load),
    .i_load_val (set_sec),
    .o_value    (second),
    .o_carry_c  (w_sec_carry)
  );

  // A manual increment in the same cycle suppresses carries out of seconds.
  mod_counter #(
    .WIDTH   (MIN_W),
    .MODULUS (MAX_MIN + 1)
  ) u_min (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_sec_carry & ~w_any_inc),
    .i_inc      (w_inc_min),
    .i_load     (w_load),
    .i_load_val (set_min),
    .o_value    (minute),
    .o_carry_c  (w_min_carry)
  );

  mod_counter #(
    .WIDTH   (HOUR_W),
    .MODULUS (MAX_HOUR + 1)
  ) u_hour (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_min_carry),
    .i_inc      (w_inc_hour),
    .i_load     (w_load),
    .i_load_val (set_hour),
    .o_value    (hour24),
    .o_carry_c  (w_hour_carry)
  );

  // Registered status pulses aligned with the edge that shows the new time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_set_err  <= 1'b0;
      r_min_tick <= 1'b0;
      r_day_tick <= 1'b0;
    end else begin
      r_set_err  <= w_fire & ~w_in_range;
      r_min_tick <= w_sec_carry;
      r_day_tick <= w_hour_carry;
    end
  end

  assign set_ready = r_set_ready;
  assign set_err   = r_set_err;
  assign min_tick  = r_min_tick;
  assign day_tick  = r_day_tick;

`ifdef CLOCK_ALARM_EN
  logic              r_alarm;
  logic              w_min_wrap;
  logic [MIN_W-1:0]  w_min_next;
  logic [HOUR_W-1:0] w_hour_next;
  logic              w_alarm_hit;

  // Time the tick-driven rollover to ss==00 is about to produce.
  assign w_min_wrap  = (minute == MIN_W'(MAX_MIN));
  assign w_min_next  = w_min_wrap ? '0 : minute + MIN_W'(1);
  assign w_hour_next = !w_min_wrap ? hour24 :
                       (hour24 == HOUR_W'(MAX_HOUR)) ? '0 : hour24 + HOUR_W'(1);
  assign w_alarm_hit = alarm_en & w_sec_carry & ~w_any_inc &
                       (w_hour_next == alarm_hour) & (w_min_next == alarm_min);

  // Alarm pulse, only from tick-driven updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alarm <= 1'b0;
    end else begin
      r_alarm <= w_alarm_hit;
    end
  end

  assign alarm = r_alarm;
`endif

endmodule

// File: tb/tb_clock_time_counter.sv
// Scoreboard bench for clock_time_counter: two instances (PRESCALE 1 and 4)
// share stimulus; a seconds-of-day reference model predicts each cycle.
// Alarm checks are included when CLOCK_ALARM_EN is defined.
module tb_clock_time_counter;

  typedef struct packed {
    logic       rdy;
    logic       err;
    logic       mt;
    logic       dt;
    logic       al;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } exp_t;

  localparam int MODE_RUN   = 0;
  localparam int MODE_PAUSE = 1;
  localparam int MODE_LOAD  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       s_rst, s_tick, s_pause, s_valid, s_incm, s_inch;
  logic [4:0] s_hour;
  logic [5:0] s_min, s_sec;
`ifdef CLOCK_ALARM_EN
  logic       s_al_en;
  logic [4:0] s_al_hour;
  logic [5:0] s_al_min;
  logic       al0, al1;
`endif

  logic       rdy0, err0, mt0, dt0, rdy1, err1, mt1, dt1;
  logic [4:0] h0, h1;
  logic [5:0] m0, s0, m1, s1;

  clock_time_counter #(.PRESCALE(1)) u_dut0 (
    .clk(clk), .rst(s_rst), .tick_in(s_tick), .pause(s_pause),
    .set_valid(s_valid), .set_ready(rdy0), .set_hour(s_hour), .set_min(s_min),
    .set_sec(s_sec), .set_err(err0), .inc_min(s_incm), .inc_hour(s_inch),
    .hour24(h0), .minute(m0), .second(s0), .min_tick(mt0), .day_tick(dt0)
`ifdef CLOCK_ALARM_EN
    , .alarm_en(s_al_en), .alarm_hour(s_al_hour), .alarm_min(s_al_min), .alarm(al0)
`endif
  );

  clock_time_counter #(.PRESCALE(4)) u_dut1 (
    .clk(clk), .rst(s_rst), .tick_in(s_tick), .pause(s_pause),
    .set_valid(s_valid), .set_ready(rdy1), .set_hour(s_hour), .set_min(s_min),
    .set_sec(s_sec), .set_err(err1), .inc_min(s_incm), .inc_hour(s_inch),
    .hour24(h1), .minute(m1), .second(s1), .min_tick(mt1), .day_tick(dt1)
`ifdef CLOCK_ALARM_EN
    , .alarm_en(s_al_en), .alarm_hour(s_al_hour), .alarm_min(s_al_min), .alarm(al1)
`endif
  );

  // Reference model state: time as seconds since midnight.
  int   m_t    [2];
  int   m_p    [2];
  int   m_mode [2];
  int   ps     [2] = '{1, 4};
  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic model_step(input int k);
    exp_t e;
    int   hr, mn, sc;
    bit   fire, ok, adv, incs;
    e = '0;
    if (s_rst) begin
      m_t[k] = 0; m_p[k] = 0; m_mode[k] = MODE_RUN;
    end else begin
      fire = s_valid && (m_mode[k] != MODE_LOAD);
      ok   = (s_hour <= 23) && (s_min <= 59) && (s_sec <= 59);
      if (fire && ok) begin
        m_t[k]    = int'(s_hour) * 3600 + int'(s_min) * 60 + int'(s_sec);
        m_p[k]    = 0;
        m_mode[k] = MODE_LOAD;
      end else begin
        e.err = fire && !ok;
        adv   = 1'b0;
        incs  = (s_incm || s_inch) && (m_mode[k] != MODE_LOAD);
        if (m_mode[k] == MODE_RUN && s_tick) begin
          if (m_p[k] == ps[k] - 1) begin m_p[k] = 0; adv = 1'b1; end
          else m_p[k] = m_p[k] + 1;
        end
        if (incs) begin
          hr = m_t[k] / 3600; mn = (m_t[k] / 60) % 60; sc = m_t[k] % 60;
          if (s_incm) mn = (mn + 1) % 60;
          if (s_inch) hr = (hr + 1) % 24;
          if (adv) begin sc = (sc + 1) % 60; e.mt = (sc == 0); end
          m_t[k] = hr * 3600 + mn * 60 + sc;
        end else if (adv) begin
          m_t[k] = (m_t[k] + 1) % 86400;
          e.mt   = (m_t[k] % 60 == 0);
          e.dt   = (m_t[k] == 0);
`ifdef CLOCK_ALARM_EN
          e.al   = s_al_en && (m_t[k] == int'(s_al_hour) * 3600 + int'(s_al_min) * 60);
`endif
        end
        m_mode[k] = s_pause ? MODE_PAUSE : MODE_RUN;
      end
    end
    e.rdy = (m_mode[k] != MODE_LOAD);
    e.h   = 5'(m_t[k] / 3600);
    e.m   = 6'((m_t[k] / 60) % 60);
    e.s   = 6'(m_t[k] % 60);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // One clock of stimulus, driven on the falling edge; expectations queued.
  task automatic drive(input bit rst, input bit tick, input bit pz, input bit valid,
                       input int hh, input int mm, input int ss,
                       input bit im, input bit ih);
    @(negedge clk);
    s_rst = rst; s_tick = tick; s_pause = pz; s_valid = valid;
    s_hour = 5'(hh); s_min = 6'(mm); s_sec = 6'(ss);
    s_incm = im; s_inch = ih;
    model_step(0);
    model_step(1);
  endtask

  task automatic idle(input bit pz, input int n);
    for (int i = 0; i < n; i++) drive(0, 0, pz, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input bit pz, input int n);
    for (int i = 0; i < n; i++) drive(0, 1, pz, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input bit pz, input int hh, input int mm, input int ss);
    drive(0, 0, pz, 1, hh, mm, ss, 0, 0);
  endtask

  task automatic compare(input int k, input exp_t a, input exp_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL out_dut%0d @%0t: got h=%0d m=%0d s=%0d rdy=%b err=%b mt=%b dt=%b al=%b, want h=%0d m=%0d s=%0d rdy=%b err=%b mt=%b dt=%b al=%b",
               k, $time, a.h, a.m, a.s, a.rdy, a.err, a.mt, a.dt, a.al,
               e.h, e.m, e.s, e.rdy, e.err, e.mt, e.dt, e.al);
    end
  endtask

  // Monitor: outputs are valid every cycle, so pop one entry per edge.
  initial begin
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        a = '0;
        a.rdy = rdy0; a.err = err0; a.mt = mt0; a.dt = dt0;
        a.h = h0; a.m = m0; a.s = s0;
`ifdef CLOCK_ALARM_EN
        a.al = al0;
`endif
        compare(0, a, q0.pop_front());
      end
      if (q1.size() > 0) begin
        a = '0;
        a.rdy = rdy1; a.err = err1; a.mt = mt1; a.dt = dt1;
        a.h = h1; a.m = m1; a.s = s1;
`ifdef CLOCK_ALARM_EN
        a.al = al1;
`endif
        compare(1, a, q1.pop_front());
      end
    end
  end

  function automatic int pick(input int maxv, input int hot, input int bad_hi);
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0)     return int'($urandom_range(maxv + 1, bad_hi));
    else if (r < 8) return hot;
    else if (r < 11) return maxv;
    else            return int'($urandom_range(0, maxv));
  endfunction

  initial begin
    bit pz;
    bit tk, vl, im, ih, rs;
    int hh, mm, ss;
    s_rst = 1; s_tick = 0; s_pause = 0; s_valid = 0; s_incm = 0; s_inch = 0;
    s_hour = 0; s_min = 0; s_sec = 0;
`ifdef CLOCK_ALARM_EN
    s_al_en = 0; s_al_hour = 0; s_al_min = 0;
`endif
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 1, 1);
    // Sixty ticks: minute rollover with single-cycle min_tick.
    ticks(0, 60);
    idle(0, 2);
    // Day rollover.
    load(0, 23, 59, 58);
    ticks(0, 2);
    ticks(0, 8);
    idle(0, 1);
    // Rejected load, then a good load.
    load(0, 24, 0, 0);
    idle(0, 2);
    load(0, 12, 30, 0);
    idle(0, 2);
    // Paused: frozen, manual increments at wrap points.
    ticks(1, 12);
    load(1, 23, 10, 5);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 1);
    load(1, 10, 59, 20);
    drive(0, 0, 1, 0, 0, 0, 0, 1, 0);
    idle(1, 2);
    // Prescaler: partial count, then load clears it.
    idle(0, 1);
    ticks(0, 3);
    ticks(0, 2);
    load(0, 5, 5, 5);
    ticks(0, 3);
    ticks(0, 1);
    // Increment racing a rollover tick.
    load(0, 23, 59, 59);
    ticks(0, 3);
    drive(0, 1, 0, 0, 0, 0, 0, 1, 0);
    idle(0, 1);
`ifdef CLOCK_ALARM_EN
    s_al_en = 1; s_al_hour = 7; s_al_min = 0;
    load(0, 6, 59, 59);
    ticks(0, 4);
    load(0, 7, 0, 0);
    ticks(0, 4);
`endif
    // Randomized traffic with occasional loads near rollover points.
    pz = 0;
    for (int c = 0; c < 3000; c++) begin
      rs = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 29) == 0) pz = ~pz;
      tk = ($urandom_range(0, 1) == 1);
      vl = ($urandom_range(0, 19) == 0);
      im = ($urandom_range(0, 24) == 0);
      ih = ($urandom_range(0, 39) == 0);
      hh = pick(23, 23, 31);
      mm = pick(59, 59, 63);
      ss = pick(59, 58, 63);
      if (vl && (hh > 23 || mm > 59 || ss > 59)) begin
        tk = 0; im = 0; ih = 0;
      end
`ifdef CLOCK_ALARM_EN
      if ($urandom_range(0, 99) == 0) begin
        s_al_en   = ($urandom_range(0, 3) != 0);
        s_al_hour = 5'($urandom_range(0, 23));
        s_al_min  = 6'($urandom_range(0, 59));
      end
      if (vl && $urandom_range(0, 3) == 0) begin
        mm = (int'(s_al_min) + 59) % 60;
        hh = (s_al_min == 0) ? (int'(s_al_hour) + 23) % 24 : int'(s_al_hour);
        ss = 59;
      end
`endif
      drive(rs, tk, pz, vl, hh, mm, ss, im, ih);
    end
    idle(0, 3);
    @(negedge clk);
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending entries, want 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
